// File: rtl/krnl_partialknn_local_sp_reader_if.sv
// Bus bundle for krnl_partialknn_local_sp_reader.
//
// Carries two groups of signals:
//   - the single-port buffer read port: address0, ce0, we0, d0 (driven by the
//     reader) and q0 (driven by the memory, ReadLatency cycles after ce0);
//   - the output word stream: out_data, out_valid (driven by the reader) and
//     out_ready (driven by the consumer).
//
// Stream handshake: a word transfers on every rising clk edge where
// out_valid and out_ready are both 1. Once out_valid is raised it stays high,
// and out_data stays unchanged, until that transfer happens; out_ready may
// change freely and the reader never waits on it before raising out_valid.
//
// Modports:
//   master - the reader (drives address0/ce0/we0/d0/out_data/out_valid)
//   slave  - the environment: memory plus stream consumer
interface krnl_partialknn_local_sp_reader_if #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11
);
    logic [AddressWidth-1:0] address0;
    logic                    ce0;
    logic                    we0;
    logic [DataWidth-1:0]    d0;
    logic [DataWidth-1:0]    q0;
    logic [DataWidth-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output address0, ce0, we0, d0, out_data, out_valid,
        input  q0, out_ready
    );

    modport slave (
        input  address0, ce0, we0, d0, out_data, out_valid,
        output q0, out_ready
    );
endinterface

// File: rtl/krnl_partialknn_local_sp_reader.sv
// Read-side initiator for the partialKnn local single-port URAM buffer.
//
// A start pulse (accepted only while idle) latches base/count and issues
// count sequential reads base, base+1, ... (wrapping at AddressRange). Read
// data comes back ReadLatency cycles after ce0 and lands in a small output
// FIFO whose head is presented as a valid/ready stream. A read is only issued
// while FIFO occupancy plus reads in flight is below FifoDepth, so returning
// data always has a slot and nothing is lost under backpressure.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - one-cycle request, sampled only in IDLE
//   base, count     - first word address and number of words (0..AddressRange)
//   bus (master)    - buffer read port and output stream (see interface file)
//   busy            - high from the cycle after accept through the done cycle
//   done            - one-cycle pulse after the last word has been handed off
//   state_dbg       - current FSM state, for observation only
module krnl_partialknn_local_sp_reader #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 2,
    parameter int FifoDepth    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [AddressWidth-1:0]              base,
    input  logic [AddressWidth:0]                count,
    krnl_partialknn_local_sp_reader_if.master    bus,
    output logic                                 busy,
    output logic                                 done,
    output logic [1:0]                           state_dbg
);

    localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntWidth = $clog2(FifoDepth + 1);
    localparam int SumWidth = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [AddressWidth-1:0] addr_q;
    logic [AddressWidth-1:0] addr_next;
    logic [AddressWidth:0]   remaining_q;

    // One bit per outstanding read; bit 0 is the read issued last cycle and
    // the top bit marks the cycle its data is on q0.
    logic [ReadLatency-1:0]  pipe_q;

    logic [DataWidth-1:0]    fifo_mem [FifoDepth];
    logic [PtrWidth-1:0]     rd_ptr;
    logic [PtrWidth-1:0]     wr_ptr;
    logic [CntWidth-1:0]     fifo_count;

    logic [SumWidth-1:0]     in_flight;
    logic [SumWidth-1:0]     credit_sum;
    logic                    credit_ok;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    fifo_nonempty;

    // ------------------------------------------------------------------
    // Credit and handshake terms
    // ------------------------------------------------------------------
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < ReadLatency; i++) begin
            in_flight = in_flight + SumWidth'(pipe_q[i]);
        end
    end

    // A pop in this cycle is not credited until the next cycle; this keeps
    // the credit check free of any path from out_ready.
    assign credit_sum    = SumWidth'(fifo_count) + in_flight;
    assign credit_ok     = credit_sum < SumWidth'(FifoDepth);
    assign issue         = (state == S_ISSUE) && credit_ok;
    assign push          = pipe_q[ReadLatency-1];
    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty && bus.out_ready;

    assign addr_next = (addr_q == AddressWidth'(AddressRange - 1))
                     ? '0 : addr_q + AddressWidth'(1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue && (remaining_q == (AddressWidth + 1)'(1))) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last word leaves when the FIFO holds exactly one word,
                // nothing is still in flight, and it is popped now.
                if (pop && (fifo_count == CntWidth'(1)) && (pipe_q == '0)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Address / remaining-count / in-flight pipe / FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            pipe_q      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            pipe_q <= ReadLatency'({pipe_q, issue});

            if ((state == S_IDLE) && start) begin
                addr_q      <= base;
                remaining_q <= count;
            end else if (issue) begin
                addr_q      <= addr_next;
                remaining_q <= remaining_q - (AddressWidth + 1)'(1);
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrWidth'(FifoDepth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
            end

            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CntWidth'(1);
                2'b01:   fifo_count <= fifo_count - CntWidth'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: out_data is forced to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.q0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs onto the bus
    // ------------------------------------------------------------------
    assign bus.address0  = addr_q;
    assign bus.ce0       = issue;
    assign bus.we0       = 1'b0;
    assign bus.d0        = '0;
    assign bus.out_valid = fifo_nonempty;
    assign bus.out_data  = fifo_nonempty ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
module tb_krnl_partialknn_local_sp_reader;

    localparam int DW = 256;
    localparam int AR = 2048;
    localparam int AW = 11;
    localparam int RL = 2;
    localparam int FD = 4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   count = '0;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    krnl_partialknn_local_sp_reader_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

    krnl_partialknn_local_sp_reader #(
        .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW),
        .ReadLatency(RL), .FifoDepth(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base(base),
        .count(count),
        .bus(bus),
        .busy(busy),
        .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory model: data for a ce0 in cycle c is on q0 in cycle c+RL;
    // otherwise q0 carries junk so a mistimed capture shows up.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [AR];
    logic [DW-1:0] rd_stage;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        rd_stage <= bus.ce0 ? mem[bus.address0] : rand_word();
        bus.q0   <= rd_stage;
    end

    // ------------------------------------------------------------------
    // Scoreboard state and check helper
    // ------------------------------------------------------------------
    int            total     = 0;
    int            bad       = 0;
    int            done_cnt  = 0;
    int            issue_cnt = 0;
    int            done_base = 0;
    int            ready_mode = 1;   // 0 = held low, 1 = held high, 2 = random
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_addr_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready driver; runs after the driver's own #1 updates.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, mid-cycle
    // ------------------------------------------------------------------
    int            outstanding;
    logic          prev_valid;
    logic          prev_ready;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            prev_data   = '0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.ce0) begin
                issue_cnt++;
                outstanding++;
                check("we0", bus.we0, 0);
                check("d0", bus.d0, 0);
                check("credit_ok", outstanding <= FD, 1);
                check("addr_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) begin
                    check("address0", bus.address0, exp_addr_q.pop_front());
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                outstanding--;
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_with_done", busy, 1);
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Start is high for one cycle (edge 0 samples it); returns 1ns into cycle 1.
    task automatic start_burst(input int b, input int c, input bit accept);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = AW'(b);
        count = (AW + 1)'(c);
        if (accept) begin
            done_base = done_cnt;
            for (int i = 0; i < c; i++) begin
                int a;
                a = (b + i) % AR;
                exp_addr_q.push_back(AW'(a));
                exp_q.push_back(mem[a]);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_burst(input int budget);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        @(posedge clk);
        #1;
        check("done_once", done_cnt - done_base, 1);
        check("busy_after_done", busy, 0);
        check("words_left", exp_q.size(), 0);
        check("addrs_left", exp_addr_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int b;
        int c;
        int dc;

        for (int i = 0; i < AR; i++) mem[i] = rand_word();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address0", bus.address0, 0);
        check("rst_ce0", bus.ce0, 0);
        check("rst_we0", bus.we0, 0);
        check("rst_d0", bus.d0, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Basic burst with hand-known cycle timing.
        for (int i = 0; i < 4; i++) mem[i] = DW'(i);
        ready_mode = 1;
        start_burst(0, 4, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("t1_ce0", bus.ce0, (k >= 1 && k <= 4));
            if (k <= 4) check("t1_addr", bus.address0, k - 1);
            check("t1_valid", bus.out_valid, (k >= 4 && k <= 7));
            if (k >= 4 && k <= 7) check("t1_data", bus.out_data, k - 4);
            check("t1_done", done, k == 8);
            check("t1_busy", busy, k <= 8);
        end
        check("t1_done_once", done_cnt - done_base, 1);
        check("t1_words_left", exp_q.size(), 0);

        // Address wrap at the top of the buffer.
        start_burst(2046, 4, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("wrap_ce0", bus.ce0, 1);
        check("wrap_addr_c3", bus.address0, 0);
        @(negedge clk);
        check("wrap_addr_c4", bus.address0, 1);
        finish_burst(100);

        // Backpressure: consumer stalled until cycle 20.
        ready_mode = 0;
        b = $urandom_range(0, AR - 1);
        dc = issue_cnt;
        start_burst(b, 8, 1);
        repeat (11) @(posedge clk);
        #1;
        check("bp_issues", issue_cnt - dc, FD);
        check("bp_valid", bus.out_valid, 1);
        check("bp_head", bus.out_data, mem[b]);
        repeat (8) @(posedge clk);
        #1;
        ready_mode = 1;
        finish_burst(200);

        // Zero-length request.
        done_base = done_cnt;
        start_burst($urandom_range(0, AR - 1), 0, 1);
        @(negedge clk);
        check("c0_done_c1", done, 1);
        check("c0_busy_c1", busy, 1);
        check("c0_ce0_c1", bus.ce0, 0);
        @(negedge clk);
        check("c0_busy_c2", busy, 0);
        check("c0_done_c2", done, 0);
        check("c0_done_once", done_cnt - done_base, 1);

        // Reset in the middle of a burst.
        ready_mode = 1;
        start_burst($urandom_range(0, AR - 1), 16, 1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        #1;
        check("mr_address0", bus.address0, 0);
        check("mr_ce0", bus.ce0, 0);
        check("mr_out_valid", bus.out_valid, 0);
        check("mr_out_data", bus.out_data, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("mr_done_held", done, 0);
        reset = 1'b0;
        dc = done_cnt;
        repeat (4) @(negedge clk);
        check("mr_no_done", done_cnt - dc, 0);
        start_burst($urandom_range(0, AR - 1), 2, 1);
        finish_burst(50);

        // A second start while busy must be ignored.
        ready_mode = 2;
        start_burst($urandom_range(0, AR - 1), 10, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = AW'($urandom_range(0, AR - 1));
        count = (AW + 1)'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_burst(500);
        repeat (3) @(negedge clk);
        check("ign_idle", busy, 0);

        // Whole buffer.
        ready_mode = 1;
        start_burst(0, AR, 1);
        finish_burst(AR + 100);

        // Random bursts under random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            b = $urandom_range(0, AR - 1);
            c = $urandom_range(1, 48);
            start_burst(b, c, 1);
            finish_burst(40 * c + 100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
